// File: rtl/cgra_config_responder.sv
// Tile-side endpoint of the CGRA configuration bus: decodes addressed reads and writes
// into a local register file, and tracks the global CONFIG/FLUSH/RUN sequence.
module cgra_config_responder #(
  parameter logic [15:0] TILE_ID   = 16'h0000,
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] REG_RESET = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [31:0]              config_config_addr,
  input  logic [31:0]              config_config_data,
  input  logic                     config_read,
  input  logic                     config_write,
  output logic [31:0]              read_config_data,
  output logic                     read_config_valid,
  output logic [32*NUM_REGS-1:0]   cfg_regs,
  output logic [15:0]              cfg_write_count,
  output logic [1:0]               cfg_state,
  output logic                     config_error
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    ST_CONFIG = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] rd_data_q;
  logic        rd_valid_q;
  logic [15:0] wr_count_q;
  logic        error_q;

  // Bus protocol: config_read / config_write are single-cycle strobes, one
  // transaction per cycle, no backpressure. A hit read is answered by exactly
  // one read_config_valid pulse on the following cycle; writes get no response.
  logic [7:0]       idx;
  logic [IDX_W-1:0] reg_sel;
  logic             hit;
  logic             wr_accept;
  logic             wr_in_run;
  logic             rd_accept;
  logic             rw_collision;

  assign idx          = config_config_addr[23:16];
  assign reg_sel      = idx[IDX_W-1:0];
  assign hit          = (config_config_addr[15:0] == TILE_ID) &&
                        ({24'd0, idx} < 32'(NUM_REGS));
  assign wr_accept    = config_write && hit && (state_q != ST_RUN);
  assign wr_in_run    = config_write && hit && (state_q == ST_RUN);
  assign rd_accept    = config_read && hit && !config_write;
  assign rw_collision = config_read && config_write && hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CONFIG;
      rd_data_q  <= 32'h0;
      rd_valid_q <= 1'b0;
      wr_count_q <= 16'h0;
      error_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RESET;
    end else begin
      // Stall wins over flush in RUN so the tile drops back to CONFIG and
      // needs a fresh flush before it may run again.
      case (state_q)
        ST_CONFIG: if (flush) state_q <= ST_FLUSH;
        ST_FLUSH:  if (!flush) state_q <= stall ? ST_CONFIG : ST_RUN;
        ST_RUN: begin
          if (stall)      state_q <= ST_CONFIG;
          else if (flush) state_q <= ST_FLUSH;
        end
        default: state_q <= ST_CONFIG;
      endcase

      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_accept && (reg_sel == IDX_W'(i))) regs_q[i] <= config_config_data;
      end

      if (wr_accept && (wr_count_q != 16'hFFFF)) wr_count_q <= wr_count_q + 16'd1;

      rd_valid_q <= rd_accept;
      if (rd_accept) rd_data_q <= regs_q[reg_sel];

      if (wr_in_run || rw_collision) error_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_regs[32*g +: 32] = regs_q[g];
  end

  assign read_config_data  = rd_data_q;
  assign read_config_valid = rd_valid_q;
  assign cfg_write_count   = wr_count_q;
  assign cfg_state         = state_q;
  assign config_error      = error_q;

endmodule
